// File: rtl/urex9_sprite_renderer.sv
// urex9 sprite fetch stage: box test, ROM addressing, walk animation
// and hit-flash blink, producing a palette index three clocks later.
module urex9_sprite_renderer #(
    parameter int          SPRITE_W        = 32,
    parameter int          SPRITE_H        = 32,
    parameter int          FRAMES          = 4,
    parameter int          FRAME_HOLD      = 8,
    parameter int          FLASH_FRAMES    = 16,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'h0,
    parameter int          ROM_AW          = $clog2(FRAMES*SPRITE_W*SPRITE_H)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vsync,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PosX,
    input  logic [9:0]        PosY,
    input  logic              Moving,
    input  logic              Hit,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              pixel_on
);

    localparam int XW = $clog2(SPRITE_W);
    localparam int YW = $clog2(SPRITE_H);
    localparam int FW = $clog2(FRAMES);
    localparam int AW = FW + YW + XW;
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int CW = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FLASH_ON,
        FLASH_OFF
    } fstate_t;

    logic          vsync_d;
    logic          fe;
    logic [9:0]    px, py;
    logic [FW-1:0] frame;
    logic [HW-1:0] hold_cnt;
    fstate_t       state, state_n;
    logic [CW-1:0] fcnt, fcnt_n;

    logic [10:0]   x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
    logic          inbox;
    logic          off0;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [AW-1:0] addr_n;

    logic          inb1, inb2;
    logic          off1, off2;

    assign fe = vsync_d & ~vsync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vsync_d <= 1'b1;
        end else begin
            vsync_d <= vsync;
        end
    end

    // Shadow position only moves at frame start so the sprite never tears.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            px <= '0;
            py <= '0;
        end else if (fe) begin
            px <= PosX;
            py <= PosY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame    <= '0;
            hold_cnt <= '0;
        end else if (fe) begin
            if (Moving) begin
                if (hold_cnt == HW'(FRAME_HOLD - 1)) begin
                    hold_cnt <= '0;
                    frame    <= frame + 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        if (Hit) begin
            state_n = FLASH_ON;
            fcnt_n  = CW'(FLASH_FRAMES);
        end else if (fe && state != IDLE) begin
            fcnt_n = fcnt - 1'b1;
            if (fcnt_n == '0) begin
                state_n = IDLE;
            end else begin
                unique case (state)
                    FLASH_ON:  state_n = FLASH_OFF;
                    FLASH_OFF: state_n = FLASH_ON;
                    default:   state_n = IDLE;
                endcase
            end
        end
    end

    // 11-bit compares let a box near the right/bottom edge clip, not wrap.
    always_comb begin
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        x_lo   = {1'b0, px};
        y_lo   = {1'b0, py};
        x_hi   = x_lo + 11'(SPRITE_W);
        y_hi   = y_lo + 11'(SPRITE_H);
        inbox  = (x_ext >= x_lo) && (x_ext < x_hi) &&
                 (y_ext >= y_lo) && (y_ext < y_hi);
        dx     = DrawX[XW-1:0] - px[XW-1:0];
        dy     = DrawY[YW-1:0] - py[YW-1:0];
        off0   = (state == FLASH_OFF);
        addr_n = inbox ? {frame, dy, dx} : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            inb1     <= 1'b0;
            off1     <= 1'b0;
            inb2     <= 1'b0;
            off2     <= 1'b0;
            index    <= TRANSPARENT_IDX;
            pixel_on <= 1'b0;
        end else begin
            rom_addr <= ROM_AW'(addr_n);
            inb1     <= inbox;
            off1     <= off0;
            inb2     <= inb1;
            off2     <= off1;
            index    <= inb2 ? rom_data : TRANSPARENT_IDX;
            pixel_on <= inb2 && (rom_data != TRANSPARENT_IDX) && !off2;
        end
    end

endmodule

// File: tb/tb_urex9_sprite_renderer.sv
// Randomised scoreboard bench for urex9_sprite_renderer with a
// frame-level reference model and a synchronous ROM model.
module tb_urex9_sprite_renderer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        vsync;
    logic [9:0]  DrawX, DrawY, PosX, PosY;
    logic        Moving, Hit;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  index;
    logic        pixel_on;

    urex9_sprite_renderer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .vsync    (vsync),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .PosX     (PosX),
        .PosY     (PosY),
        .Moving   (Moving),
        .Hit      (Hit),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .index    (index),
        .pixel_on (pixel_on)
    );

    always #5 Clk = ~Clk;

    logic [3:0] mem [4096];
    always @(posedge Clk) rom_data <= mem[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [3:0] idx;
        logic       on;
    } pexp_t;

    typedef struct {
        int          due;
        logic [11:0] addr;
    } aexp_t;

    pexp_t pq[$];
    aexp_t aq[$];
    int checks = 0;
    int errors = 0;

    // reference model state: fst 0=idle, 1=visible blink, 2=blank blink
    int m_px = 0, m_py = 0, m_frame = 0, m_hold = 0, m_fst = 0, m_fcnt = 0;

    function automatic void push_px(int x, int y);
        bit         inb;
        int         a;
        logic [3:0] d;
        pexp_t      pe;
        aexp_t      ae;
        inb = (x >= m_px) && (x < m_px + 32) && (y >= m_py) && (y < m_py + 32);
        a   = inb ? (m_frame * 1024 + (y - m_py) * 32 + (x - m_px)) : 0;
        d   = mem[a];
        ae.due  = cyc + 1;
        ae.addr = 12'(a);
        pe.due  = cyc + 3;
        pe.idx  = inb ? d : 4'h0;
        pe.on   = inb && (d != 4'h0) && (m_fst != 2);
        aq.push_back(ae);
        pq.push_back(pe);
    endfunction

    aexp_t ea;
    pexp_t ep;
    always @(negedge Clk) begin
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ea = aq.pop_front();
            checks++;
            if (ea.due != cyc || rom_addr !== ea.addr) begin
                errors++;
                $display("FAIL rom_addr cyc=%0d got %h want %h",
                         cyc, rom_addr, ea.addr);
            end
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            ep = pq.pop_front();
            checks++;
            if (ep.due != cyc || index !== ep.idx) begin
                errors++;
                $display("FAIL index cyc=%0d got %h want %h",
                         cyc, index, ep.idx);
            end
            checks++;
            if (ep.due != cyc || pixel_on !== ep.on) begin
                errors++;
                $display("FAIL pixel_on cyc=%0d got %b want %b",
                         cyc, pixel_on, ep.on);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        repeat (5) tick();
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic sweep(int y, int x0, int x1);
        for (int x = x0; x <= x1; x++) begin
            DrawX = 10'(x);
            DrawY = 10'(y);
            push_px(x, y);
            tick();
        end
    endtask

    task automatic model_fe(bit h);
        m_px = int'(PosX);
        m_py = int'(PosY);
        if (Moving) begin
            m_hold++;
            if (m_hold == 8) begin
                m_hold  = 0;
                m_frame = (m_frame + 1) % 4;
            end
        end else begin
            m_hold = 0;
        end
        if (h) begin
            m_fst  = 1;
            m_fcnt = 16;
        end else if (m_fst != 0) begin
            m_fcnt--;
            if (m_fcnt == 0) m_fst = 0;
            else m_fst = 3 - m_fst;
        end
    endtask

    task automatic vpulse(bit h);
        vsync = 1'b0;
        Hit   = h;
        model_fe(h);
        tick();
        Hit = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (2) tick();
    endtask

    task automatic hit_pulse();
        Hit    = 1'b1;
        m_fst  = 1;
        m_fcnt = 16;
        tick();
        Hit = 1'b0;
        tick();
    endtask

    task automatic do_reset(int n);
        drain();
        Reset = 1'b1;
        tick();
        @(negedge Clk);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_index", int'(index), 0);
        chk("reset_pixel_on", int'(pixel_on), 0);
        @(posedge Clk);
        #1;
        repeat (n - 1) tick();
        Reset   = 1'b0;
        m_px    = 0;
        m_py    = 0;
        m_frame = 0;
        m_hold  = 0;
        m_fst   = 0;
        m_fcnt  = 0;
        tick();
    endtask

    task automatic frame_sweep();
        vpulse(1'b0);
        sweep(m_py + 10, m_px + 4, m_px + 19);
    endtask

    initial begin
        int y, x0;
        Reset  = 1'b1;
        vsync  = 1'b1;
        DrawX  = '0;
        DrawY  = '0;
        PosX   = '0;
        PosY   = '0;
        Moving = 1'b0;
        Hit    = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 4'h3;
        do_reset(3);

        PosX = 10'd100;
        PosY = 10'd50;
        vpulse(1'b0);
        sweep(60, 98, 133);

        for (int i = 0; i < 32; i++) mem[10 * 32 + i] = 4'h0;
        sweep(60, 98, 133);
        sweep(61, 98, 133);

        for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);

        PosX = 10'd630;
        PosY = 10'd400;
        vpulse(1'b0);
        sweep(410, 620, 639);
        sweep(411, 0, 40);

        PosX = 10'd100;
        PosY = 10'd50;
        vpulse(1'b0);
        sweep(60, 90, 140);
        PosX = 10'd200;
        sweep(61, 90, 240);
        vpulse(1'b0);
        sweep(62, 90, 240);

        Moving = 1'b1;
        repeat (40) frame_sweep();
        while (m_hold != 5) frame_sweep();
        Moving = 1'b0;
        frame_sweep();
        Moving = 1'b1;
        repeat (10) frame_sweep();
        Moving = 1'b0;

        hit_pulse();
        repeat (18) frame_sweep();

        hit_pulse();
        repeat (7) frame_sweep();
        hit_pulse();
        repeat (18) frame_sweep();

        hit_pulse();
        repeat (3) frame_sweep();
        vpulse(1'b1);
        sweep(m_py + 3, m_px, m_px + 8);
        repeat (18) frame_sweep();

        repeat (40) begin
            PosX   = 10'($urandom_range(0, 660));
            PosY   = 10'($urandom_range(0, 490));
            Moving = 1'($urandom);
            if ($urandom_range(0, 3) == 0) hit_pulse();
            vpulse($urandom_range(0, 4) == 0);
            y  = m_py + $urandom_range(0, 40) - 4;
            x0 = m_px - $urandom_range(0, 5);
            if (y < 0) y = 0;
            if (x0 < 0) x0 = 0;
            sweep(y, x0, x0 + 40);
        end

        Moving = 1'b0;
        hit_pulse();
        repeat (3) frame_sweep();
        PosX = 10'd300;
        do_reset(2);
        sweep(5, 0, 40);

        drain();
        chk("queues_empty", aq.size() + pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/urex9_sprite_renderer.md
# urex9_sprite_renderer

Per-pixel sprite fetch stage for the urex9 character, directly upstream of `urex9_palette`. Each cycle it:
- takes the VGA scan coordinate;
- decides whether the pixel lies inside the sprite box;
- generates the sprite-ROM address for the current animation frame;
- emits the 4-bit palette index and a pixel-on flag, three clocks later.

It also owns the frame-synchronous state: the position latch, the walk-animation counter and the hit-flash blink FSM.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- FRAMES, 4, animation frames stored back-to-back in ROM (power of two)
- FRAME_HOLD, 8, vsync periods each animation frame is shown
- FLASH_FRAMES, 16, vsync periods of hit blinking (even)
- TRANSPARENT_IDX, 4'h0, palette index treated as see-through
- ROM_AW, $clog2(FRAMES*SPRITE_W*SPRITE_H), ROM address width

Ports (name, direction, width, meaning):
- Clk, in, 1, pixel clock; the only clock
- Reset, in, 1, synchronous, active-high
- vsync, in, 1, VGA vertical sync, active-low
- DrawX, in, 10, current scan column
- DrawY, in, 10, current scan row
- PosX, in, 10, sprite top-left column from game logic
- PosY, in, 10, sprite top-left row from game logic
- Moving, in, 1, level; enables walk animation
- Hit, in, 1, one-cycle pulse; starts blinking
- rom_addr, out, ROM_AW, registered address to the synchronous sprite ROM (1-cycle read latency)
- rom_data, in, 4, palette index returned by the ROM
- index, out, 4, palette index to `urex9_palette`
- pixel_on, out, 1, sprite pixel is opaque and visible

## Operation
**Frame edge (fe):** one-cycle internal pulse on the vsync 1→0 transition.
- vsync_d resets to 1, so a low vsync at reset release does not produce fe.

**Position latch:** PosX/PosY are copied into shadow registers pX/pY on fe only. Mid-frame position changes never tear the sprite.

**Box test (stage 0):**
- inbox = (DrawX ≥ pX) && ({1'b0,DrawX} < pX+SPRITE_W) && (same for Y).
- Comparisons use 11-bit arithmetic, so a sprite near column 639 / row 479 clips and never wraps.
- dx = DrawX−pX and dy = DrawY−pY, truncated to log2 of the sprite width/height.
- Address = {frame, dy, dx}, registered into rom_addr. When !inbox, rom_addr holds 0.

**Pipeline:**
- inbox and the blink-off flag are delayed to align with rom_data.
- Stage 2 registers:
  - index = inbox ? rom_data : TRANSPARENT_IDX
  - pixel_on = inbox && rom_data≠TRANSPARENT_IDX && state≠FLASH_OFF

**Animation counter:**
- On fe with Moving=1: hold_cnt increments. When hold_cnt=FRAME_HOLD−1, hold_cnt wraps to 0 and frame=(frame+1) mod FRAMES.
- On fe with Moving=0: hold_cnt clears to 0 and frame holds.
- frame and hold_cnt change only on fe.

**Flash FSM** (states IDLE, FLASH_ON, FLASH_OFF; counter fcnt):
- IDLE: on Hit → FLASH_ON, fcnt=FLASH_FRAMES.
- FLASH_ON/OFF: on fe, fcnt decrements. If the result is 0 → IDLE; otherwise ON↔OFF toggles.
- Hit in any state restarts at FLASH_ON with fcnt=FLASH_FRAMES. Hit beats a same-cycle fe.
- The FLASH_OFF condition for pixel_on is sampled at stage 0 and piped with the pixel data.

## Timing
- **Latency:** DrawX/DrawY at edge t → rom_addr at t+1 → rom_data valid before t+2 → index/pixel_on at t+3. Fixed 3 cycles. The VGA side delays its own blanking by 3 to match.
- **Throughput:** one pixel per clock, with no stalls.
- **fe:** detected 1 cycle after vsync falls. pX/pY, frame and the FSM update at the edge following that detection.
- **Reset** (any cycle, including mid-frame or mid-blink), on the next edge:
  - rom_addr=0, index=TRANSPARENT_IDX, pixel_on=0
  - pX=pY=0, frame=0, hold_cnt=0, fcnt=0
  - state=IDLE, all pipeline flags 0, vsync_d=1
- **While Reset is high:** all inputs are ignored.

## Test plan
- **Reset:** assert Reset for 2 cycles mid-scan → index=0, pixel_on=0, rom_addr=0 on the edge after assertion; frame=0.
- **Box and latency:** PosX=100, PosY=50 latched by fe; sweep DrawY=60, DrawX 98..133 with ROM model data=4'h3.
  - pixel_on is 1 for DrawX 100..131, 3 cycles delayed.
  - rom_addr at DrawX=105 is {0, 5'd10, 5'd5}.
- **Transparency and clipping:**
  - ROM returns 4'h0 inside the box → pixel_on=0, index=0.
  - PosX=630 → pixel_on only for DrawX 630..639, no wrap at column 0.
- **Position latch:** change PosX mid-frame from 100 to 200 → box stays at 100 until the next fe, then moves to 200.
- **Animation:**
  - Moving=1 for 40 vsyncs → frame sequence 0,1,2,3,0 changing every 8 fe.
  - Drop Moving at hold_cnt=5 → frame holds and hold_cnt=0.
- **Flash:**
  - Hit pulse → pixel_on alternates visible/blank per frame for 16 fe, then steady visible in IDLE.
  - Second Hit at fe 7 → restarts 16 full periods.
  - Hit coincident with fe → FLASH_ON, fcnt=16.
